// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: operand request side plus the
// registered result/flag side, both using valid/ready handshakes.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, illegal, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, illegal, busy
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered WIDTH-bit execute-stage ALU. Logic/arithmetic ops finish in one
// cycle; shifts iterate SHIFT_STEP bits per cycle through a working register.
module alu_multicycle #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_multicycle_if.slave   bus
);
    localparam int SW     = $clog2(WIDTH);
    localparam int STEP_W = SW + 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SW-1:0]    rem_q, rem_d;
    logic [1:0]       kind_q, kind_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             out_valid_q, out_valid_d;

    logic             in_ready_c;
    logic             accept_c;
    logic             is_shift_c;
    logic [SW-1:0]    shamt_c;

    // Bitwise ops built as per-bit slices
    logic [WIDTH-1:0] and_v, or_v, xor_v;
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        assign and_v[gi] = bus.a[gi] & bus.b[gi];
        assign or_v[gi]  = bus.a[gi] | bus.b[gi];
        assign xor_v[gi] = bus.a[gi] ^ bus.b[gi];
    end

    logic [WIDTH:0] sum_add, sum_sub;
    logic           ovf_add, ovf_sub;
    assign sum_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign ovf_add = (bus.a[MSB] == bus.b[MSB]) && (sum_add[MSB] != bus.a[MSB]);
    assign ovf_sub = (bus.a[MSB] != bus.b[MSB]) && (sum_sub[MSB] != bus.a[MSB]);

    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v, sc_ill;
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
        case (bus.op)
            OP_AND:  sc_res = and_v;
            OP_OR:   sc_res = or_v;
            OP_XOR:  sc_res = xor_v;
            OP_ADD:  begin sc_res = sum_add[MSB:0]; sc_c = sum_add[WIDTH]; sc_v = ovf_add; end
            OP_SUB:  begin sc_res = sum_sub[MSB:0]; sc_c = sum_sub[WIDTH]; sc_v = ovf_sub; end
            OP_SLT:  begin sc_res = {{(WIDTH-1){1'b0}}, sum_sub[MSB] ^ ovf_sub}; sc_c = sum_sub[WIDTH]; end
            OP_SLTU: begin sc_res = {{(WIDTH-1){1'b0}}, ~sum_sub[WIDTH]}; sc_c = sum_sub[WIDTH]; end
            // Only reached with a zero shift amount: result passes a through
            OP_SLL, OP_SRL, OP_SRA: sc_res = bus.a;
            default: sc_ill = 1'b1;
        endcase
    end

    assign is_shift_c = (bus.op == OP_SLL) || (bus.op == OP_SRL) || (bus.op == OP_SRA);
    assign shamt_c    = bus.b[SW-1:0];
    assign in_ready_c = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Per-cycle step never exceeds what is left, so the last step may be short
    logic [STEP_W-1:0] rem_ext, step;
    logic [SW-1:0]     rem_after;
    logic [WIDTH-1:0]  shifted;
    assign rem_ext   = {1'b0, rem_q};
    assign step      = (rem_ext < STEP_W'(SHIFT_STEP)) ? rem_ext : STEP_W'(SHIFT_STEP);
    assign rem_after = SW'(rem_ext - step);

    always_comb begin
        case (kind_q)
            2'b00:   shifted = work_q << step;
            2'b01:   shifted = work_q >> step;
            default: shifted = WIDTH'($signed(work_q) >>> step);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        rem_d       = rem_q;
        kind_d      = kind_q;
        result_d    = result_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (is_shift_c && (shamt_c != '0)) begin
                        work_d  = bus.a;
                        rem_d   = shamt_c;
                        kind_d  = bus.op[1:0];
                        state_d = SHIFT;
                    end else begin
                        result_d    = sc_res;
                        carry_d     = sc_c;
                        ovf_d       = sc_v;
                        illegal_d   = sc_ill;
                        zero_d      = (sc_res == '0) && !sc_ill;
                        out_valid_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = shifted;
                rem_d  = rem_after;
                if (rem_after == '0) begin
                    result_d    = shifted;
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                    zero_d      = (shifted == '0);
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            rem_q       <= '0;
            kind_q      <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            rem_q       <= rem_d;
            kind_q      <= kind_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
    assign bus.busy      = (state_q == SHIFT);
endmodule
